// File: rtl/feedback_arbiter.sv
// Arbitrates the shared LED/tone feedback resource between sequence display,
// button echo and win/lose jingles; each phase is timed in prescaled ticks.
module feedback_arbiter #(
    parameter int TICK_DIV    = 12000,
    parameter int ON_TICKS    = 300,
    parameter int GAP_TICKS   = 100,
    parameter int ECHO_TICKS  = 150,
    parameter int JNOTE_TICKS = 120
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SEQ_REQ,
    input  logic [1:0] SEQ_COLOR,
    output logic       SEQ_ACK,
    input  logic       ECHO_VALID,
    input  logic [1:0] ECHO_COLOR,
    input  logic       WIN,
    input  logic       LOSE,
    output logic [3:0] LED,
    output logic [2:0] TONE_SEL,
    output logic       BUSY
);

    typedef enum logic [2:0] {IDLE, SEQ_ON, SEQ_GAP, ECHO_ON, WIN_NOTE, LOSE_NOTE} state_t;

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] P_PEN  = PW'(TICK_DIV - 2);
    localparam logic [9:0] ON_L    = 10'(ON_TICKS - 1);
    localparam logic [9:0] GAP_L   = 10'(GAP_TICKS - 1);
    localparam logic [9:0] ECHO_L  = 10'(ECHO_TICKS - 1);
    localparam logic [9:0] JNOTE_L = 10'(JNOTE_TICKS - 1);
    localparam logic [9:0] LOSE_L  = 10'(4 * JNOTE_TICKS - 1);

    state_t      state;
    logic [PW-1:0] presc;
    logic [9:0]  tcnt;
    logic [1:0]  note;
    logic [1:0]  cur_col;
    logic [1:0]  echo_col;
    logic        win_p, lose_p, echo_p;
    logic        holdoff;

    logic tick, last_tick, seq_live;
    logic start_win, start_lose, start_seq, start_echo;

    assign tick      = (presc == P_LAST);
    assign last_tick = tick && (tcnt == 10'd0);
    // A request still high in the cycle right after its ACK belongs to the
    // colour just finished, so it is masked for exactly that cycle.
    assign seq_live   = SEQ_REQ && !holdoff;
    assign start_win  = (state == IDLE) && win_p;
    assign start_lose = (state == IDLE) && !win_p && lose_p;
    assign start_seq  = (state == IDLE) && !win_p && !lose_p && seq_live;
    assign start_echo = (state == IDLE) && !win_p && !lose_p && !seq_live && echo_p;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            win_p    <= 1'b0;
            lose_p   <= 1'b0;
            echo_p   <= 1'b0;
            echo_col <= 2'd0;
        end else begin
            if (WIN)            win_p  <= 1'b1;
            else if (start_win) win_p  <= 1'b0;
            if (LOSE)            lose_p <= 1'b1;
            else if (start_lose) lose_p <= 1'b0;
            // Jingles flush any pending echo; a press in the same cycle survives.
            if (ECHO_VALID)
                echo_p <= 1'b1;
            else if (start_win || start_lose || start_echo)
                echo_p <= 1'b0;
            if (ECHO_VALID) echo_col <= ECHO_COLOR;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            presc    <= '0;
            tcnt     <= 10'd0;
            note     <= 2'd0;
            cur_col  <= 2'd0;
            holdoff  <= 1'b0;
            SEQ_ACK  <= 1'b0;
            LED      <= 4'd0;
            TONE_SEL <= 3'd0;
            BUSY     <= 1'b0;
        end else begin
            SEQ_ACK <= 1'b0;
            holdoff <= 1'b0;
            presc   <= tick ? '0 : presc + 1'b1;
            if (tick && tcnt != 10'd0) tcnt <= tcnt - 10'd1;

            case (state)
                IDLE: begin
                    presc <= '0;
                    if (start_win) begin
                        state    <= WIN_NOTE;
                        note     <= 2'd0;
                        tcnt     <= JNOTE_L;
                        LED      <= 4'b0001;
                        TONE_SEL <= 3'd5;
                        BUSY     <= 1'b1;
                    end else if (start_lose) begin
                        state    <= LOSE_NOTE;
                        tcnt     <= LOSE_L;
                        LED      <= 4'b1111;
                        TONE_SEL <= 3'd6;
                        BUSY     <= 1'b1;
                    end else if (start_seq) begin
                        state    <= SEQ_ON;
                        cur_col  <= SEQ_COLOR;
                        tcnt     <= ON_L;
                        LED      <= 4'b0001 << SEQ_COLOR;
                        TONE_SEL <= {1'b0, SEQ_COLOR} + 3'd1;
                        BUSY     <= 1'b1;
                    end else if (start_echo) begin
                        state    <= ECHO_ON;
                        cur_col  <= echo_col;
                        tcnt     <= ECHO_L;
                        LED      <= 4'b0001 << echo_col;
                        TONE_SEL <= {1'b0, echo_col} + 3'd1;
                        BUSY     <= 1'b1;
                    end
                end
                SEQ_ON: if (last_tick) begin
                    state    <= SEQ_GAP;
                    presc    <= '0;
                    tcnt     <= GAP_L;
                    LED      <= 4'd0;
                    TONE_SEL <= 3'd0;
                end
                SEQ_GAP: begin
                    // Registered ACK: raise it on entry to the final gap cycle.
                    if (tcnt == 10'd0 && presc == P_PEN) SEQ_ACK <= 1'b1;
                    if (last_tick) begin
                        state   <= IDLE;
                        BUSY    <= 1'b0;
                        holdoff <= 1'b1;
                    end
                end
                WIN_NOTE: if (last_tick) begin
                    if (note == 2'd3) begin
                        state    <= IDLE;
                        LED      <= 4'd0;
                        TONE_SEL <= 3'd0;
                        BUSY     <= 1'b0;
                    end else begin
                        note <= note + 2'd1;
                        tcnt <= JNOTE_L;
                        LED  <= 4'b0001 << (note + 2'd1);
                    end
                end
                ECHO_ON, LOSE_NOTE: if (last_tick) begin
                    state    <= IDLE;
                    LED      <= 4'd0;
                    TONE_SEL <= 3'd0;
                    BUSY     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_feedback_arbiter.sv
// Scoreboard bench: each scenario queues the per-cycle expected outputs,
// then drives stimulus and compares every cycle as the DUT produces it.
module tb_feedback_arbiter;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       SEQ_REQ = 1'b0;
    logic [1:0] SEQ_COLOR = 2'd0;
    logic       SEQ_ACK;
    logic       ECHO_VALID = 1'b0;
    logic [1:0] ECHO_COLOR = 2'd0;
    logic       WIN = 1'b0;
    logic       LOSE = 1'b0;
    logic [3:0] LED;
    logic [2:0] TONE_SEL;
    logic       BUSY;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] led;
        logic [2:0] tone;
        logic       ack;
        logic       busy;
    } exp_t;
    exp_t q[$];

    feedback_arbiter #(
        .TICK_DIV(4), .ON_TICKS(3), .GAP_TICKS(2), .ECHO_TICKS(2), .JNOTE_TICKS(1)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .SEQ_REQ(SEQ_REQ), .SEQ_COLOR(SEQ_COLOR), .SEQ_ACK(SEQ_ACK),
        .ECHO_VALID(ECHO_VALID), .ECHO_COLOR(ECHO_COLOR),
        .WIN(WIN), .LOSE(LOSE),
        .LED(LED), .TONE_SEL(TONE_SEL), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic void push_n(logic [3:0] led, logic [2:0] tone, logic ack, logic busy, int n);
        exp_t e;
        e.led = led; e.tone = tone; e.ack = ack; e.busy = busy;
        for (int i = 0; i < n; i++) q.push_back(e);
    endfunction

    task automatic test_reset();
        exp_t e;
        int c = 0;
        RST_N = 1'b0;
        push_n(4'd0, 3'd0, 1'b0, 1'b0, 3);
        while (q.size() != 0) begin
            @(negedge CLK);
            e = q.pop_front();
            n_tests++;
            if ({LED, TONE_SEL, SEQ_ACK, BUSY} !== {e.led, e.tone, e.ack, e.busy}) begin
                n_fail++;
                $display("FAIL reset c%0d: got LED=%b TONE=%0d ACK=%b BUSY=%b, want LED=%b TONE=%0d ACK=%b BUSY=%b",
                         c, LED, TONE_SEL, SEQ_ACK, BUSY, e.led, e.tone, e.ack, e.busy);
            end
            @(posedge CLK); #1;
            c++;
        end
        RST_N = 1'b1;
    endtask

    task automatic test_seq_display();
        exp_t e;
        int c = 0;
        push_n(4'd0, 3'd0, 1'b0, 1'b0, 1);
        push_n(4'b0100, 3'd3, 1'b0, 1'b1, 12);
        push_n(4'd0, 3'd0, 1'b0, 1'b1, 7);
        push_n(4'd0, 3'd0, 1'b1, 1'b1, 1);
        push_n(4'd0, 3'd0, 1'b0, 1'b0, 2);
        while (q.size() != 0) begin
            SEQ_REQ = (c < 21); SEQ_COLOR = 2'd2;
            @(negedge CLK);
            e = q.pop_front();
            n_tests++;
            if ({LED, TONE_SEL, SEQ_ACK, BUSY} !== {e.led, e.tone, e.ack, e.busy}) begin
                n_fail++;
                $display("FAIL seq_display c%0d: got LED=%b TONE=%0d ACK=%b BUSY=%b, want LED=%b TONE=%0d ACK=%b BUSY=%b",
                         c, LED, TONE_SEL, SEQ_ACK, BUSY, e.led, e.tone, e.ack, e.busy);
            end
            @(posedge CLK); #1;
            c++;
        end
        SEQ_REQ = 1'b0;
    endtask

    task automatic test_holdoff();
        exp_t e;
        int c;
        // Request held through the holdoff cycle only: no restart.
        c = 0;
        push_n(4'd0, 3'd0, 1'b0, 1'b0, 1);
        push_n(4'b0010, 3'd2, 1'b0, 1'b1, 12);
        push_n(4'd0, 3'd0, 1'b0, 1'b1, 7);
        push_n(4'd0, 3'd0, 1'b1, 1'b1, 1);
        push_n(4'd0, 3'd0, 1'b0, 1'b0, 3);
        while (q.size() != 0) begin
            SEQ_REQ = (c <= 21); SEQ_COLOR = 2'd1;
            @(negedge CLK);
            e = q.pop_front();
            n_tests++;
            if ({LED, TONE_SEL, SEQ_ACK, BUSY} !== {e.led, e.tone, e.ack, e.busy}) begin
                n_fail++;
                $display("FAIL holdoff_drop c%0d: got LED=%b TONE=%0d ACK=%b BUSY=%b, want LED=%b TONE=%0d ACK=%b BUSY=%b",
                         c, LED, TONE_SEL, SEQ_ACK, BUSY, e.led, e.tone, e.ack, e.busy);
            end
            @(posedge CLK); #1;
            c++;
        end
        // Request still high in cycle 22: second display starts in cycle 23.
        c = 0;
        push_n(4'd0, 3'd0, 1'b0, 1'b0, 1);
        push_n(4'b0001, 3'd1, 1'b0, 1'b1, 12);
        push_n(4'd0, 3'd0, 1'b0, 1'b1, 7);
        push_n(4'd0, 3'd0, 1'b1, 1'b1, 1);
        push_n(4'd0, 3'd0, 1'b0, 1'b0, 2);
        push_n(4'b0001, 3'd1, 1'b0, 1'b1, 12);
        push_n(4'd0, 3'd0, 1'b0, 1'b1, 7);
        push_n(4'd0, 3'd0, 1'b1, 1'b1, 1);
        push_n(4'd0, 3'd0, 1'b0, 1'b0, 1);
        while (q.size() != 0) begin
            SEQ_REQ = (c <= 22); SEQ_COLOR = 2'd0;
            @(negedge CLK);
            e = q.pop_front();
            n_tests++;
            if ({LED, TONE_SEL, SEQ_ACK, BUSY} !== {e.led, e.tone, e.ack, e.busy}) begin
                n_fail++;
                $display("FAIL holdoff_hold c%0d: got LED=%b TONE=%0d ACK=%b BUSY=%b, want LED=%b TONE=%0d ACK=%b BUSY=%b",
                         c, LED, TONE_SEL, SEQ_ACK, BUSY, e.led, e.tone, e.ack, e.busy);
            end
            @(posedge CLK); #1;
            c++;
        end
        SEQ_REQ = 1'b0;
    endtask

    task automatic test_echo_coalesce();
        exp_t e;
        int c = 0;
        push_n(4'd0, 3'd0, 1'b0, 1'b0, 1);
        push_n(4'b0001, 3'd1, 1'b0, 1'b1, 12);
        push_n(4'd0, 3'd0, 1'b0, 1'b1, 7);
        push_n(4'd0, 3'd0, 1'b1, 1'b1, 1);
        push_n(4'd0, 3'd0, 1'b0, 1'b0, 1);
        push_n(4'b1000, 3'd4, 1'b0, 1'b1, 8);
        push_n(4'd0, 3'd0, 1'b0, 1'b0, 4);
        while (q.size() != 0) begin
            SEQ_REQ    = (c < 21); SEQ_COLOR = 2'd0;
            ECHO_VALID = (c == 2 || c == 5);
            ECHO_COLOR = (c == 2) ? 2'd1 : 2'd3;
            @(negedge CLK);
            e = q.pop_front();
            n_tests++;
            if ({LED, TONE_SEL, SEQ_ACK, BUSY} !== {e.led, e.tone, e.ack, e.busy}) begin
                n_fail++;
                $display("FAIL echo_coalesce c%0d: got LED=%b TONE=%0d ACK=%b BUSY=%b, want LED=%b TONE=%0d ACK=%b BUSY=%b",
                         c, LED, TONE_SEL, SEQ_ACK, BUSY, e.led, e.tone, e.ack, e.busy);
            end
            @(posedge CLK); #1;
            c++;
        end
        SEQ_REQ = 1'b0; ECHO_VALID = 1'b0;
    endtask

    task automatic test_jingles();
        exp_t e;
        int c = 0;
        push_n(4'd0, 3'd0, 1'b0, 1'b0, 2);
        push_n(4'b0001, 3'd5, 1'b0, 1'b1, 4);
        push_n(4'b0010, 3'd5, 1'b0, 1'b1, 4);
        push_n(4'b0100, 3'd5, 1'b0, 1'b1, 4);
        push_n(4'b1000, 3'd5, 1'b0, 1'b1, 4);
        push_n(4'd0, 3'd0, 1'b0, 1'b0, 1);
        push_n(4'b1111, 3'd6, 1'b0, 1'b1, 16);
        push_n(4'd0, 3'd0, 1'b0, 1'b0, 4);
        while (q.size() != 0) begin
            WIN = (c == 0); LOSE = (c == 0);
            ECHO_VALID = (c == 0); ECHO_COLOR = 2'd2;
            @(negedge CLK);
            e = q.pop_front();
            n_tests++;
            if ({LED, TONE_SEL, SEQ_ACK, BUSY} !== {e.led, e.tone, e.ack, e.busy}) begin
                n_fail++;
                $display("FAIL jingles c%0d: got LED=%b TONE=%0d ACK=%b BUSY=%b, want LED=%b TONE=%0d ACK=%b BUSY=%b",
                         c, LED, TONE_SEL, SEQ_ACK, BUSY, e.led, e.tone, e.ack, e.busy);
            end
            @(posedge CLK); #1;
            c++;
        end
        WIN = 1'b0; LOSE = 1'b0; ECHO_VALID = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int c = 0;
        push_n(4'd0, 3'd0, 1'b0, 1'b0, 1);
        push_n(4'b1000, 3'd4, 1'b0, 1'b1, 5);
        push_n(4'd0, 3'd0, 1'b0, 1'b0, 3);
        push_n(4'b1000, 3'd4, 1'b0, 1'b1, 12);
        push_n(4'd0, 3'd0, 1'b0, 1'b1, 7);
        push_n(4'd0, 3'd0, 1'b1, 1'b1, 1);
        push_n(4'd0, 3'd0, 1'b0, 1'b0, 2);
        while (q.size() != 0) begin
            SEQ_REQ = (c < 29); SEQ_COLOR = 2'd3;
            RST_N   = !(c == 6 || c == 7);
            @(negedge CLK);
            e = q.pop_front();
            n_tests++;
            if ({LED, TONE_SEL, SEQ_ACK, BUSY} !== {e.led, e.tone, e.ack, e.busy}) begin
                n_fail++;
                $display("FAIL reset_mid c%0d: got LED=%b TONE=%0d ACK=%b BUSY=%b, want LED=%b TONE=%0d ACK=%b BUSY=%b",
                         c, LED, TONE_SEL, SEQ_ACK, BUSY, e.led, e.tone, e.ack, e.busy);
            end
            @(posedge CLK); #1;
            c++;
        end
        SEQ_REQ = 1'b0; RST_N = 1'b1;
    endtask

    initial begin
        @(posedge CLK); #1;
        test_reset();
        test_seq_display();
        test_holdoff();
        test_echo_coalesce();
        test_jingles();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
